// File: rtl/execute_mc.sv
// execute_mc: registered execute stage. Single-cycle ALU ops and branch/jump
// resolution, plus an iterative shift-add multiplier and restoring divider
// (RV32M semantics at XLEN width). The output register is the EX/MEM register.
module execute_mc #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk_i,
  input  logic            reset_n_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rD1_i,
  input  logic [XLEN-1:0] rD2_i,
  input  logic [XLEN-1:0] ext_i,
  input  logic            op_A_sel_i,
  input  logic            op_B_sel_i,
  input  logic [4:0]      alu_opcode_i,
  input  logic            md_en_i,
  input  logic [2:0]      md_op_i,
  input  logic [1:0]      pc_sel_i,
  input  logic            branch_ctrl_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o
);

  typedef enum logic [1:0] {IDLE, BUSY, FIN} state_t;

  // ALU opcode encoding; branch opcodes also produce the branch flag.
  localparam logic [4:0] ALU_ADD  = 5'd0,  ALU_SUB  = 5'd1,  ALU_SLL  = 5'd2;
  localparam logic [4:0] ALU_SLT  = 5'd3,  ALU_SLTU = 5'd4,  ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6,  ALU_SRA  = 5'd7,  ALU_OR   = 5'd8;
  localparam logic [4:0] ALU_AND  = 5'd9,  ALU_BEQ  = 5'd10, ALU_BNE  = 5'd11;
  localparam logic [4:0] ALU_BLT  = 5'd12, ALU_BGE  = 5'd13, ALU_BLTU = 5'd14;
  localparam logic [4:0] ALU_BGEU = 5'd15, ALU_PASB = 5'd16;

  localparam int SH_W = $clog2(XLEN);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [2:0]          md_op_q;
  logic [XLEN-1:0]     mcand;     // multiplicand (mul) or divisor (div) magnitude
  logic [XLEN-1:0]     p_hi;      // product high half / partial remainder
  logic [XLEN-1:0]     p_lo;      // multiplier bits / dividend-then-quotient
  logic                neg_q;     // negate product or quotient
  logic                neg_r;     // negate remainder
  logic                div_zero;
  logic                div_ovf;
  logic [XLEN-1:0]     dvd_raw;   // raw dividend for the special cases

  logic                out_free;
  logic                accept;
  assign out_free   = ~out_valid_o | out_ready_i;
  assign in_ready_o = reset_n_i & (state == IDLE) & out_free & ~flush_i;
  assign accept     = in_valid_i & in_ready_o;

  // ALU operands and single-cycle result / branch flag
  logic [XLEN-1:0] op_a, op_b, alu_res;
  logic [SH_W-1:0] shamt;
  logic            alu_flag;
  assign op_a  = op_A_sel_i ? pc_i  : rD1_i;
  assign op_b  = op_B_sel_i ? ext_i : rD2_i;
  assign shamt = op_b[SH_W-1:0];

  // Combinational ALU
  always_comb begin
    // NOTE: every output gets a default first so no case path infers a latch.
    alu_res  = '0;
    alu_flag = 1'b0;
    case (alu_opcode_i)
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_SLL:  alu_res = op_a << shamt;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_SRL:  alu_res = op_a >> shamt;
      ALU_SRA:  alu_res = $signed(op_a) >>> shamt;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_AND:  alu_res = op_a & op_b;
      ALU_BEQ:  alu_flag = (op_a == op_b);
      ALU_BNE:  alu_flag = (op_a != op_b);
      ALU_BLT:  alu_flag = ($signed(op_a) <  $signed(op_b));
      ALU_BGE:  alu_flag = ($signed(op_a) >= $signed(op_b));
      ALU_BLTU: alu_flag = (op_a <  op_b);
      ALU_BGEU: alu_flag = (op_a >= op_b);
      ALU_PASB: alu_res = op_b;
      default:  alu_res = '0;
    endcase
    if (alu_opcode_i >= ALU_BEQ && alu_opcode_i <= ALU_BGEU)
      alu_res = {{(XLEN-1){1'b0}}, alu_flag};
  end

  // Next-PC resolution for the single-cycle path
  logic [XLEN-1:0] alu_target, jalr_sum;
  logic            alu_redirect;
  assign jalr_sum = rD1_i + ext_i;
  always_comb begin
    alu_target   = pc_i + ext_i;
    alu_redirect = 1'b0;
    case (pc_sel_i)
      2'd1:    alu_redirect = branch_ctrl_i & alu_flag;
      2'd2:    alu_redirect = 1'b1;
      2'd3:    begin
                 alu_redirect = 1'b1;
                 alu_target   = {jalr_sum[XLEN-1:1], 1'b0};
               end
      default: alu_redirect = 1'b0;
    endcase
  end

  // Operand conditioning for the mul/div unit at accept
  logic a_signed, b_signed, sa, sb;
  logic [XLEN-1:0] a_mag, b_mag;
  assign a_signed = (md_op_i == 3'd0) | (md_op_i == 3'd1) | (md_op_i == 3'd2) |
                    (md_op_i == 3'd4) | (md_op_i == 3'd6);
  assign b_signed = (md_op_i == 3'd0) | (md_op_i == 3'd1) |
                    (md_op_i == 3'd4) | (md_op_i == 3'd6);
  assign sa    = a_signed & rD1_i[XLEN-1];
  assign sb    = b_signed & rD2_i[XLEN-1];
  assign a_mag = sa ? -rD1_i : rD1_i;
  assign b_mag = sb ? -rD2_i : rD2_i;

  // One shift-add or restoring-subtract step
  logic [XLEN:0] mul_sum, div_shift, div_diff;
  assign mul_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mcand} : '0);
  assign div_shift = {p_hi, p_lo[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, mcand};

  // Sign fix and half/quotient/remainder selection for FIN
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quot, rem, md_result;
  assign prod_s = neg_q ? -{p_hi, p_lo} : {p_hi, p_lo};
  assign quot   = neg_q ? -p_lo : p_lo;
  assign rem    = neg_r ? -p_hi : p_hi;
  always_comb begin
    md_result = '0;
    case (md_op_q)
      3'd0:             md_result = prod_s[XLEN-1:0];
      3'd1, 3'd2, 3'd3: md_result = prod_s[2*XLEN-1:XLEN];
      3'd4, 3'd5:       md_result = div_zero ? '1 : (div_ovf ? dvd_raw : quot);
      default:          md_result = div_zero ? dvd_raw : (div_ovf ? '0 : rem);
    endcase
  end

  // FSM, mul/div datapath and EX/MEM output register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state         <= IDLE;
      cnt           <= '0;
      md_op_q       <= '0;
      mcand         <= '0;
      p_hi          <= '0;
      p_lo          <= '0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      div_zero      <= 1'b0;
      div_ovf       <= 1'b0;
      dvd_raw       <= '0;
      out_valid_o   <= 1'b0;
      result_o      <= '0;
      redirect_o    <= 1'b0;
      redirect_pc_o <= '0;
    end else if (flush_i) begin
      // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
      state       <= IDLE;
      cnt         <= '0;
      out_valid_o <= 1'b0;
      redirect_o  <= 1'b0;
    end else begin
      if (out_valid_o && out_ready_i) out_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && !md_en_i) begin
            out_valid_o   <= 1'b1;
            result_o      <= alu_res;
            redirect_o    <= alu_redirect;
            redirect_pc_o <= alu_target;
          end else if (accept) begin
            md_op_q  <= md_op_i;
            mcand    <= md_op_i[2] ? b_mag : a_mag;
            p_lo     <= md_op_i[2] ? a_mag : b_mag;
            p_hi     <= '0;
            neg_q    <= sa ^ sb;
            neg_r    <= sa;
            div_zero <= (rD2_i == '0);
            div_ovf  <= b_signed && (rD1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rD2_i == '1);
            dvd_raw  <= rD1_i;
            cnt      <= '0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (md_op_q[2]) begin
            if (!div_diff[XLEN]) begin
              p_hi <= div_diff[XLEN-1:0];
              p_lo <= {p_lo[XLEN-2:0], 1'b1};
            end else begin
              p_hi <= div_shift[XLEN-1:0];
              p_lo <= {p_lo[XLEN-2:0], 1'b0};
            end
          end else begin
            {p_hi, p_lo} <= {mul_sum, p_lo[XLEN-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(XLEN - 1)) state <= FIN;
        end
        FIN: begin
          if (out_free) begin
            out_valid_o   <= 1'b1;
            result_o      <= md_result;
            redirect_o    <= 1'b0;
            redirect_pc_o <= '0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_mc.sv
// Self-checking bench for execute_mc: directed scenarios plus randomized ALU
// and mul/div ops compared against a plain-arithmetic reference model.
module tb_execute_mc;
  localparam int XLEN = 32;

  logic            clk_i = 1'b0;
  logic            reset_n_i, flush_i, in_valid_i, in_ready_o;
  logic [XLEN-1:0] pc_i, rD1_i, rD2_i, ext_i;
  logic            op_A_sel_i, op_B_sel_i, md_en_i, branch_ctrl_i;
  logic [4:0]      alu_opcode_i;
  logic [2:0]      md_op_i;
  logic [1:0]      pc_sel_i;
  logic            out_valid_o, out_ready_i, redirect_o;
  logic [XLEN-1:0] result_o, redirect_pc_o;

  int n_checks = 0;
  int n_fail   = 0;

  execute_mc #(.XLEN(XLEN)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .pc_i(pc_i),
    .rD1_i(rD1_i), .rD2_i(rD2_i), .ext_i(ext_i),
    .op_A_sel_i(op_A_sel_i), .op_B_sel_i(op_B_sel_i),
    .alu_opcode_i(alu_opcode_i), .md_en_i(md_en_i), .md_op_i(md_op_i),
    .pc_sel_i(pc_sel_i), .branch_ctrl_i(branch_ctrl_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .result_o(result_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [4:0] ADD = 5'd0, BEQ = 5'd10, BNE = 5'd11;
  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, DIV = 3'd4, DIVU = 3'd5;
  localparam logic [2:0] REM = 3'd6, REMU = 3'd7;
  localparam logic [31:0] MIN_NEG = 32'h8000_0000;

  // ---------------- reference model ----------------
  function automatic logic alu_flag_model(input logic [4:0] op, input logic [31:0] a, b);
    case (op)
      5'd10: return a == b;
      5'd11: return a != b;
      5'd12: return $signed(a) <  $signed(b);
      5'd13: return $signed(a) >= $signed(b);
      5'd14: return a <  b;
      5'd15: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] alu_model(input logic [4:0] op, input logic [31:0] a, b);
    int sh = int'(b[4:0]);
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a << sh;
      5'd3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd4:  return (a < b) ? 32'd1 : 32'd0;
      5'd5:  return a ^ b;
      5'd6:  return a >> sh;
      5'd7:  return $signed(a) >>> sh;
      5'd8:  return a | b;
      5'd9:  return a & b;
      5'd16: return b;
      default: return (op >= 5'd10 && op <= 5'd15) ? {31'd0, alu_flag_model(op, a, b)} : 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] md_model(input logic [2:0] op, input logic [31:0] a, b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ub = longint'({32'd0, b});
    logic [63:0] p;
    int qi, ri;
    case (op)
      3'd0: begin p = 64'(a * b); return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN_NEG && b == 32'hFFFF_FFFF) return a;
        qi = $signed(a) / $signed(b); return qi;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN_NEG && b == 32'hFFFF_FFFF) return 32'd0;
        ri = $signed(a) % $signed(b); return ri;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return MIN_NEG;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic drive_op(input logic md, input logic [2:0] mop, input logic [4:0] aop,
                          input logic asel, input logic bsel, input logic [31:0] pc,
                          input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] ext,
                          input logic [1:0] psel, input logic bctrl);
    md_en_i = md; md_op_i = mop; alu_opcode_i = aop; op_A_sel_i = asel; op_B_sel_i = bsel;
    pc_i = pc; rD1_i = r1; rD2_i = r2; ext_i = ext; pc_sel_i = psel; branch_ctrl_i = bctrl;
  endtask

  // Presents the driven op until accepted (bounded); returns just after the accept edge.
  task automatic issue(output bit ok);
    ok = 1'b0;
    in_valid_i = 1'b1;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (in_ready_o) begin ok = 1'b1; break; end
      @(posedge clk_i);
    end
    if (ok) @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL issue_timeout: in_ready_o never rose within 200 cycles");
    end
  endtask

  // Counts edges after the accept edge until out_valid_o, and cycles with in_ready_o high.
  task automatic wait_out(input int maxc, output int edges, output int rdy_hi);
    edges = 0; rdy_hi = 0;
    while (!out_valid_o && edges < maxc) begin
      if (in_ready_o) rdy_hi++;
      step();
      edges++;
    end
  endtask

  task automatic settle();
    in_valid_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b1;
    step(); step();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n_i = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    drive_op(0, 0, ADD, 0, 0, 0, 0, 0, 0, 0, 0);
    step(); step();
    n_checks++;
    if ({out_valid_o, redirect_o, result_o, redirect_pc_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%0b redir=%0b result=%h pc=%h, required all 0",
               out_valid_o, redirect_o, result_o, redirect_pc_o);
    end
    reset_n_i = 1'b1;
    #1;
    n_checks++;
    if (in_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: in_ready_o=%b, required 1", in_ready_o);
    end
    step();
  endtask

  task automatic test_back_to_back();
    settle();
    drive_op(0, 0, ADD, 0, 0, 32'h40, 32'd5, 32'd7, 0, 0, 0);
    in_valid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++;
      if (in_ready_o !== 1'b1) begin
        n_fail++; $display("FAIL b2b_ready[%0d]: in_ready_o=%b, required 1", k, in_ready_o);
      end
      @(posedge clk_i); #1;
      n_checks++;
      if (out_valid_o !== 1'b1 || result_o !== 32'd12) begin
        n_fail++;
        $display("FAIL b2b_result[%0d]: valid=%b result=%h, required 1 / 0000000c",
                 k, out_valid_o, result_o);
      end
    end
    in_valid_i = 1'b0;
  endtask

  task automatic test_alu_random();
    bit ok; int edges, rdy;
    logic [4:0] op; logic asel, bsel; logic [31:0] pc, r1, r2, ext, exp_r;
    settle();
    for (int k = 0; k < 30; k++) begin
      op = 5'($urandom_range(0, 17)); asel = 1'($urandom); bsel = 1'($urandom);
      pc = $urandom; r1 = $urandom; r2 = $urandom; ext = $urandom;
      if (k % 5 == 0) r2 = r1;
      drive_op(0, 0, op, asel, bsel, pc, r1, r2, ext, 0, 0);
      exp_r = alu_model(op, asel ? pc : r1, bsel ? ext : r2);
      issue(ok);
      wait_out(5, edges, rdy);
      n_checks++;
      if (edges !== 0 || result_o !== exp_r || redirect_o !== 1'b0) begin
        n_fail++;
        $display("FAIL alu_rand op=%0d: lat=%0d result=%h redir=%b, required 0 / %h / 0",
                 op, edges, result_o, redirect_o, exp_r);
      end
    end
  endtask

  task automatic test_mulh_latency();
    bit ok; int edges, rdy;
    settle();
    drive_op(1, MULH, ADD, 0, 0, 0, MIN_NEG, MIN_NEG, 0, 0, 0);
    issue(ok);
    wait_out(100, edges, rdy);
    n_checks++;
    if (edges !== 33) begin
      n_fail++; $display("FAIL mulh_latency: %0d edges, required 33", edges);
    end
    n_checks++;
    if (rdy !== 0) begin
      n_fail++; $display("FAIL mulh_ready_low: in_ready_o high %0d cycles, required 0", rdy);
    end
    n_checks++;
    if (result_o !== 32'h4000_0000) begin
      n_fail++; $display("FAIL mulh_result: %h, required 40000000", result_o);
    end
  endtask

  typedef struct { logic [2:0] op; logic [31:0] a, b, exp_r; } md_case_t;

  task automatic test_div_special();
    bit ok; int edges, rdy;
    md_case_t tbl[6];
    tbl[0] = '{DIV,  32'h1234,     32'd0,         32'hFFFF_FFFF};
    tbl[1] = '{REM,  MIN_NEG,      32'hFFFF_FFFF, 32'd0};
    tbl[2] = '{DIVU, 32'd100,      32'd7,         32'd14};
    tbl[3] = '{REMU, 32'd100,      32'd7,         32'd2};
    tbl[4] = '{DIV,  MIN_NEG,      32'hFFFF_FFFF, MIN_NEG};
    tbl[5] = '{REM,  32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9};
    settle();
    foreach (tbl[i]) begin
      drive_op(1, tbl[i].op, ADD, 0, 0, 0, tbl[i].a, tbl[i].b, 0, 0, 0);
      issue(ok);
      wait_out(100, edges, rdy);
      n_checks++;
      if (edges !== 33 || result_o !== tbl[i].exp_r) begin
        n_fail++;
        $display("FAIL div_special[%0d]: lat=%0d result=%h, required 33 / %h",
                 i, edges, result_o, tbl[i].exp_r);
      end
    end
  endtask

  task automatic test_md_random();
    bit ok; int edges, rdy;
    logic [2:0] op; logic [31:0] a, b, exp_r;
    settle();
    for (int k = 0; k < 40; k++) begin
      op = 3'($urandom_range(0, 7)); a = pick_operand(); b = pick_operand();
      exp_r = md_model(op, a, b);
      drive_op(1, op, 5'($urandom), 1'($urandom), 1'($urandom), $urandom, a, b, $urandom,
               2'($urandom), 1'($urandom));
      issue(ok);
      wait_out(100, edges, rdy);
      n_checks++;
      if (edges !== 33 || result_o !== exp_r || redirect_o !== 1'b0) begin
        n_fail++;
        $display("FAIL md_rand op=%0d a=%h b=%h: lat=%0d result=%h redir=%b, required 33 / %h / 0",
                 op, a, b, edges, result_o, redirect_o, exp_r);
      end
    end
  endtask

  typedef struct { logic [4:0] aop; logic [31:0] pc, r1, r2, ext; logic [1:0] psel; logic bctrl; } br_case_t;

  task automatic test_branch();
    bit ok; int edges, rdy; logic exp_redir; logic [31:0] exp_pc, s;
    br_case_t tbl[6];
    tbl[0] = '{BEQ, 32'h100, 32'd5, 32'd5, 32'h20, 2'd1, 1'b1};
    tbl[1] = '{BNE, 32'h100, 32'd5, 32'd5, 32'h20, 2'd1, 1'b1};
    tbl[2] = '{BEQ, 32'h100, 32'd5, 32'd5, 32'h20, 2'd1, 1'b0};
    tbl[3] = '{ADD, 32'h400, 32'd0, 32'd4, 32'hFFFF_FFF8, 2'd2, 1'b0};
    tbl[4] = '{ADD, 32'h500, 32'h203, 32'd4, 32'd0, 2'd3, 1'b0};
    tbl[5] = '{ADD, 32'h600, 32'h1, 32'h2, 32'h10, 2'd0, 1'b0};
    settle();
    foreach (tbl[i]) begin
      drive_op(0, 0, tbl[i].aop, 0, 0, tbl[i].pc, tbl[i].r1, tbl[i].r2, tbl[i].ext,
               tbl[i].psel, tbl[i].bctrl);
      case (tbl[i].psel)
        2'd1:    exp_redir = tbl[i].bctrl && alu_flag_model(tbl[i].aop, tbl[i].r1, tbl[i].r2);
        2'd0:    exp_redir = 1'b0;
        default: exp_redir = 1'b1;
      endcase
      s = tbl[i].r1 + tbl[i].ext;
      exp_pc = (tbl[i].psel == 2'd3) ? (s & 32'hFFFF_FFFE) : tbl[i].pc + tbl[i].ext;
      issue(ok);
      wait_out(5, edges, rdy);
      n_checks++;
      if (redirect_o !== exp_redir || (exp_redir && redirect_pc_o !== exp_pc)) begin
        n_fail++;
        $display("FAIL branch[%0d]: redir=%b pc=%h, required %b / %h",
                 i, redirect_o, redirect_pc_o, exp_redir, exp_pc);
      end
    end
    n_checks++;
    if (md_model(DIVU, 32'd100, 32'd7) !== 32'd14 || redirect_pc_o === 32'hx) begin
      n_fail++; $display("FAIL model_sanity: divu model %h, required 0000000e",
                         md_model(DIVU, 32'd100, 32'd7));
    end
  endtask

  task automatic test_backpressure();
    bit ok; int edges, rdy; logic [31:0] exp_m;
    settle();
    exp_m = md_model(MUL, 32'h0001_2345, 32'hFFFF_FF03);
    drive_op(1, MUL, ADD, 0, 0, 0, 32'h0001_2345, 32'hFFFF_FF03, 0, 0, 0);
    issue(ok);
    out_ready_i = 1'b0;
    wait_out(100, edges, rdy);
    drive_op(0, 0, ADD, 0, 0, 0, 32'd20, 32'd22, 0, 0, 0);
    in_valid_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++;
      if (in_ready_o !== 1'b0) begin
        n_fail++; $display("FAIL stall_ready[%0d]: in_ready_o=%b, required 0", k, in_ready_o);
      end
      @(posedge clk_i); #1;
      n_checks++;
      if (out_valid_o !== 1'b1 || result_o !== exp_m) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: valid=%b result=%h, required 1 / %h",
                 k, out_valid_o, result_o, exp_m);
      end
    end
    out_ready_i = 1'b1;
    #1;
    n_checks++;
    if (in_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL consume_accept_ready: in_ready_o=%b, required 1", in_ready_o);
    end
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    n_checks++;
    if (out_valid_o !== 1'b1 || result_o !== 32'd42) begin
      n_fail++;
      $display("FAIL consume_accept: valid=%b result=%h, required 1 / 0000002a",
               out_valid_o, result_o);
    end
  endtask

  task automatic test_flush();
    bit ok; int seen;
    settle();
    drive_op(1, DIV, ADD, 0, 0, 0, 32'd1000, 32'd3, 0, 0, 0);
    issue(ok);
    repeat (10) step();
    flush_i = 1'b1;
    #1;
    n_checks++;
    if (in_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_ready: in_ready_o=%b during flush, required 0", in_ready_o);
    end
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    drive_op(0, 0, ADD, 0, 0, 0, 32'd3, 32'd4, 0, 0, 0);
    in_valid_i = 1'b1;
    #1;
    n_checks++;
    if (in_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL post_flush_ready: in_ready_o=%b, required 1", in_ready_o);
    end
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    n_checks++;
    if (out_valid_o !== 1'b1 || result_o !== 32'd7) begin
      n_fail++;
      $display("FAIL post_flush_op: valid=%b result=%h, required 1 / 00000007", out_valid_o, result_o);
    end
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (out_valid_o) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL flush_abort: out_valid_o high %0d cycles, required 0", seen);
    end
  endtask

  task automatic test_reset_mid_divide();
    bit ok; int seen;
    settle();
    drive_op(0, 0, ADD, 0, 0, 32'h800, 32'd9, 32'd9, 32'h40, 2'd2, 0);
    issue(ok);
    drive_op(1, DIVU, ADD, 0, 0, 0, 32'd5000, 32'd7, 0, 0, 0);
    issue(ok);
    repeat (10) step();
    reset_n_i = 1'b0;
    #1;
    n_checks++;
    if ({out_valid_o, redirect_o, in_ready_o, result_o, redirect_pc_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_div: valid=%b redir=%b ready=%b result=%h pc=%h, required all 0",
               out_valid_o, redirect_o, in_ready_o, result_o, redirect_pc_o);
    end
    step(); step();
    reset_n_i = 1'b1;
    #1;
    n_checks++;
    if (in_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: in_ready_o=%b, required 1", in_ready_o);
    end
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (out_valid_o) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL reset_abort: out_valid_o high %0d cycles, required 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_alu_random();
    test_mulh_latency();
    test_div_special();
    test_md_random();
    test_branch();
    test_backpressure();
    test_flush();
    test_reset_mid_divide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/execute_mc.md
# execute_mc

Parametrised, registered execute stage for the pipelined core: wraps the existing `aluop_selector`/`alu` pair for single-cycle ops, adds an iterative multiply/divide unit (RV32M semantics at XLEN width) and next-PC/redirect resolution. It sits between decode and memory, with valid/ready handshakes on both sides. Its output register is the EX/MEM pipeline register.

## Interface
Parameters:
- XLEN, 32, datapath width (≥8, even)
- CNT_W, $clog2(XLEN)+1, iteration counter width

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- reset_n_i  in  1  asynchronous, active-low reset
- flush_i  in  1  synchronous kill of the in-flight op and the output register
- in_valid_i  in  1  decode presents an op
- in_ready_o  out  1  stage accepts op this cycle
- pc_i  in  XLEN  PC of the op
- rD1_i, rD2_i  in  XLEN  register operands
- ext_i  in  XLEN  sign-extended immediate / offset
- op_A_sel_i, op_B_sel_i  in  1  ALU operand selects, existing encoding
- alu_opcode_i  in  5  ALU opcode, existing encoding
- md_en_i  in  1  op goes to the mul/div unit instead of the ALU
- md_op_i  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- pc_sel_i  in  2  0 seq, 1 cond branch, 2 JAL, 3 JALR
- branch_ctrl_i  in  1  op is a conditional branch
- out_valid_o  out  1  output register holds a result
- out_ready_i  in  1  memory stage consumes the result
- result_o  out  XLEN  ALU or mul/div result
- redirect_o  out  1  qualified by out_valid_o: fetch must go to redirect_pc_o
- redirect_pc_o  out  XLEN  target PC

## Operation
- FSM states: IDLE, BUSY (mul/div iterating), FIN (sign fix and write-back).
- in_ready_o = (state==IDLE) & (~out_valid_o | out_ready_i) & ~flush_i.
- Accept = in_valid_i & in_ready_o.
- Accept with md_en_i=0: the ALU result, redirect and target are written to the output register on the same edge.
  - JAL target = pc+ext.
  - JALR target = (rD1+ext) & ~1.
  - Branch target = pc+ext, taken iff branch_ctrl_i & alu branch flag.
  - redirect_o = taken branch | JAL | JALR.
- Accept with md_en_i=1: operand magnitudes, sign flags and md_op are latched; counter = 0; state moves to BUSY. Ops with md_en_i=1 never redirect.
- BUSY performs one iteration per cycle.
  - Multiply: shift-add on magnitudes, 2·XLEN product.
  - Divide: restoring, one quotient bit per cycle.
  - After XLEN iterations, state moves to FIN.
- FIN applies signs and selects the low or high product half, or the quotient or remainder. It writes the output register, sets out_valid_o and returns to IDLE.
- Divide special cases (decided at accept; latency unchanged):
  - Divide by zero: quotient = all ones, remainder = dividend.
  - Signed overflow (most-negative / −1): quotient = dividend, remainder = 0.
- Output register holds all of its contents stable while out_valid_o & ~out_ready_i.
- flush_i has priority over everything: out_valid_o←0, redirect_o←0, state←IDLE, counter cleared, no accept that cycle.

## Timing
- Reset (async assert, sync deassert by environment): state IDLE; out_valid_o, redirect_o, result_o and redirect_pc_o all 0; in_ready_o 1 once reset_n_i is high.
- ALU latency is 1: accept at edge E0, out_valid_o high after E0.
- Mul/div latency is XLEN+1: accept E0, iterations E1..E_XLEN, FIN write at E_(XLEN+1). in_ready_o stays low from E0 until the cycle after FIN.
- Back-to-back ALU ops run at 1 per cycle when out_ready_i is held high.
- Simultaneous consume and accept: the output register is overwritten on the same edge, with no bubble.
- FIN while out_valid_o & ~out_ready_i: FSM holds in FIN until the register frees. The result is never dropped.
- flush_i during BUSY/FIN: the op is aborted and nothing is written.

## Test plan
- Reset mid-divide (assert reset_n_i low at iteration 10) -> all outputs 0 immediately; in_ready_o = 1 after release.
- ADD rD1=5, rD2=7, out_ready_i held 1, 4 back-to-back accepts -> result_o = 12 each cycle, in_ready_o never drops.
- MULH rD1=0x80000000, rD2=0x80000000 -> result_o = 0x40000000 exactly 33 edges after accept; in_ready_o low for that span.
- DIV rD2=0 with rD1=0x1234 -> 0xFFFFFFFF; REM rD1=0x80000000, rD2=0xFFFFFFFF -> 0; DIVU 100/7 -> 14, REMU -> 2.
- Taken branch at pc=0x100, ext=0x20 -> redirect_o = 1 and redirect_pc_o = 0x120; JALR rD1=0x203, ext=0 -> redirect_pc_o = 0x202.
- out_ready_i low for 5 cycles after a MUL result -> result_o stable and no accept; flush_i mid-BUSY -> out_valid_o stays 0 and the next op is accepted the following cycle.
